// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM self-test sequencer.
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int DEF_ADDR_WIDTH = 20;
   localparam int DEF_DATA_WIDTH = 8;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/sram_tester_if.sv
// Request/response bus between the self-test sequencer and sram_1Mx8.
interface sram_tester_if
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  o_write;
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [DATA_WIDTH-1:0] o_data;
   logic [DATA_WIDTH-1:0] i_data;

   modport master (output o_write, output o_addr, output o_data, input i_data);
   modport slave  (input o_write, input o_addr, input o_data, output i_data);
endinterface

// File: rtl/sram_tester_pattern_gen.sv
// Test pattern source; SRAM_TESTER_LFSR_EN selects the LFSR over the address-derived pattern.
module pattern_gen
   import sram_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] PATTERN_XOR = DATA_WIDTH'(8'hA5)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_reload,
   input  logic                  i_advance,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [DATA_WIDTH-1:0] o_pattern
);
   logic [DATA_WIDTH-1:0] pattern_d, pattern_q;

`ifdef SRAM_TESTER_LFSR_EN
   if (DATA_WIDTH != 8) begin : g_bad_width
      $error("pattern_gen: LFSR pattern requires DATA_WIDTH == 8");
   end

   logic unused_addr;
   assign unused_addr = ^i_addr;

   // Reseeding on every pass start gives both passes the identical sequence
   always_comb begin
      pattern_d = pattern_q;
      if (i_reload) begin
         pattern_d = DATA_WIDTH'(LFSR_SEED);
      end else if (i_advance) begin
         pattern_d = DATA_WIDTH'({pattern_q[6:0], ^(pattern_q[7:0] & LFSR_TAPS)});
      end
   end
`else
   logic [DATA_WIDTH-1:0] addr_lo;

   if (ADDR_WIDTH >= DATA_WIDTH) begin : g_trunc
      assign addr_lo = i_addr[DATA_WIDTH-1:0];
      if (ADDR_WIDTH > DATA_WIDTH) begin : g_hi
         logic unused_hi;
         assign unused_hi = ^i_addr[ADDR_WIDTH-1:DATA_WIDTH];
      end
   end else begin : g_ext
      assign addr_lo = DATA_WIDTH'(i_addr);
   end

   // i_addr is the address of the slot about to start, so the pattern lines up with it
   always_comb begin
      pattern_d = pattern_q;
      if (i_reload || i_advance) begin
         pattern_d = addr_lo ^ PATTERN_XOR;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pattern_q <= '0;
      end else begin
         pattern_q <= pattern_d;
      end
   end

   assign o_pattern = pattern_q;
endmodule

// File: rtl/sram_tester.sv
// SRAM BIST sequencer: write pass, then read-and-compare pass over the full address space.
// Build option: SRAM_TESTER_LFSR_EN switches the data pattern to an 8-bit LFSR.
module sram_tester
   import sram_pkg::*;
#(
   parameter int                    ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int                    DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int                    ACCESS_CYCLES = 4,
   parameter logic [DATA_WIDTH-1:0] PATTERN_XOR   = DATA_WIDTH'(8'hA5)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   sram_tester_if.master         sram,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_pass,
   output logic [15:0]           o_err_count,
   output logic [ADDR_WIDTH-1:0] o_err_addr
);
   localparam int SLOT_W = $clog2(ACCESS_CYCLES);

   if (ACCESS_CYCLES < 2) begin : g_bad_cycles
      $error("sram_tester: ACCESS_CYCLES must be at least 2");
   end

   state_e                state_d, state_q;
   logic [SLOT_W-1:0]     slot_d, slot_q;
   logic [ADDR_WIDTH-1:0] addr_d, addr_q;
   logic [15:0]           err_cnt_d, err_cnt_q;
   logic [ADDR_WIDTH-1:0] err_addr_d, err_addr_q;
   logic                  write_d, write_q;
   logic                  busy_d, busy_q;
   logic                  done_d, done_q;
   logic                  pass_d, pass_q;
   logic                  reload, advance;
   logic                  slot_last, addr_last;
   logic [DATA_WIDTH-1:0] pattern;

   pattern_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .DATA_WIDTH  (DATA_WIDTH),
      .PATTERN_XOR (PATTERN_XOR)
   ) u_pattern (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_reload  (reload),
      .i_advance (advance),
      .i_addr    (addr_d),
      .o_pattern (pattern)
   );

   assign slot_last = (slot_q == SLOT_W'(ACCESS_CYCLES - 1));
   assign addr_last = &addr_q;

   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      addr_d     = addr_q;
      err_cnt_d  = err_cnt_q;
      err_addr_d = err_addr_q;
      write_d    = write_q;
      busy_d     = busy_q;
      done_d     = done_q;
      pass_d     = pass_q;
      reload     = 1'b0;
      advance    = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               state_d    = WRITE;
               slot_d     = '0;
               addr_d     = '0;
               err_cnt_d  = '0;
               err_addr_d = '0;
               write_d    = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               pass_d     = 1'b0;
               reload     = 1'b1;
            end
         end
         WRITE: begin
            if (slot_last) begin
               slot_d = '0;
               if (addr_last) begin
                  // Straight into read address 0, no dead cycle between passes
                  state_d = READ;
                  addr_d  = '0;
                  write_d = 1'b0;
                  reload  = 1'b1;
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  advance = 1'b1;
               end
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         READ: begin
            if (slot_last) begin
               // Read data is only guaranteed settled in the last cycle of the slot
               if (sram.i_data != pattern) begin
                  if (err_cnt_q == 16'h0000) begin
                     err_addr_d = addr_q;
                  end
                  if (err_cnt_q != 16'hFFFF) begin
                     err_cnt_d = err_cnt_q + 16'd1;
                  end
               end
               slot_d = '0;
               if (addr_last) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_d == 16'h0000);
               end else begin
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  advance = 1'b1;
               end
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         slot_q     <= '0;
         addr_q     <= '0;
         err_cnt_q  <= '0;
         err_addr_q <= '0;
         write_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         addr_q     <= addr_d;
         err_cnt_q  <= err_cnt_d;
         err_addr_q <= err_addr_d;
         write_q    <= write_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign sram.o_write = write_q;
   assign sram.o_addr  = addr_q;
   assign sram.o_data  = pattern;
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_pass       = pass_q;
   assign o_err_count  = err_cnt_q;
   assign o_err_addr   = err_addr_q;
endmodule
